// File: rtl/pose_match_scorer_pkg.sv
// Shared types and default raster geometry for the pose scoring path.
package pose_score_pkg;

    localparam int H_ACT_DEF = 640;
    localparam int V_ACT_DEF = 480;

    typedef enum logic [1:0] {
        MISS    = 2'd0,
        GOOD    = 2'd1,
        PERFECT = 2'd2
    } grade_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_LATCH   = 2'd2,
        ST_EVAL    = 2'd3
    } state_e;

endpackage

// File: rtl/pose_match_scorer_pixel_tally.sv
// Per-frame pixel class counters: polygon area, foreground inside, foreground outside.
module pixel_tally #(
    parameter int CNT_W = 19
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic             in_polygon,
    input  logic             bg_pixel,
    output logic [CNT_W-1:0] poly_cnt,
    output logic [CNT_W-1:0] fill_cnt,
    output logic [CNT_W-1:0] spill_cnt
);

    logic fg;
    logic poly_inc;
    logic fill_inc;
    logic spill_inc;

    assign fg        = ~bg_pixel;
    assign poly_inc  = en & in_polygon;
    assign fill_inc  = en & in_polygon & fg;
    assign spill_inc = en & ~in_polygon & fg;

    // A clear restarts the tally from the current pixel so the frame's first pixel is kept.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            poly_cnt  <= '0;
            fill_cnt  <= '0;
            spill_cnt <= '0;
        end else if (clr) begin
            poly_cnt  <= CNT_W'(poly_inc);
            fill_cnt  <= CNT_W'(fill_inc);
            spill_cnt <= CNT_W'(spill_inc);
        end else if (en) begin
            poly_cnt  <= poly_cnt  + CNT_W'(poly_inc);
            fill_cnt  <= fill_cnt  + CNT_W'(fill_inc);
            spill_cnt <= spill_cnt + CNT_W'(spill_inc);
        end
    end

endmodule

// File: rtl/pose_match_scorer.sv
// End-of-frame pose judge: tallies pixel classes, grades fill/spill ratios, tracks combo.
module pose_match_scorer
    import pose_score_pkg::*;
#(
    parameter int H_ACT       = H_ACT_DEF,
    parameter int V_ACT       = V_ACT_DEF,
    parameter int CNT_W       = 19,
    parameter int PERFECT_PCT = 90,
    parameter int GOOD_PCT    = 70,
    parameter int SPILL_PCT   = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             DE,
    input  logic [9:0]       x_pixel,
    input  logic [9:0]       y_pixel,
    input  logic             in_polygon,
    input  logic             bg_pixel,
    input  logic             judge_en,
    output logic             score_valid,
    output grade_e           grade,
    output logic [CNT_W-1:0] fill_cnt,
    output logic [CNT_W-1:0] spill_cnt,
    output logic [CNT_W-1:0] poly_cnt,
    output logic [7:0]       combo,
    output logic             busy
);

    localparam int PROD_W = CNT_W + 7;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic grade_e grade_of(input logic poly_nz, input logic spill_ok,
                                        input logic [PROD_W-1:0] a,
                                        input logic [PROD_W-1:0] p,
                                        input logic [PROD_W-1:0] g);
        if (poly_nz && spill_ok && a >= p)
            return PERFECT;
        else if (poly_nz && spill_ok && a >= g)
            return GOOD;
        return MISS;
    endfunction

    state_e           state;
    state_e           state_nxt;
    logic             tally_clr;
    logic             tally_en;
    logic             first_px;
    logic             last_px;
    logic [CNT_W-1:0] poly_t;
    logic [CNT_W-1:0] fill_t;
    logic [CNT_W-1:0] spill_t;

    logic [PROD_W-1:0] a_p1;
    logic [PROD_W-1:0] p_p1;
    logic [PROD_W-1:0] g_p1;
    logic [PROD_W-1:0] s_p1;
    logic [PROD_W-1:0] t_p1;
    logic              spill_ok_p2;
    grade_e            grade_p2;

    assign first_px = DE && (x_pixel == 10'd0) && (y_pixel == 10'd0);
    assign last_px  = DE && (x_pixel == 10'(H_ACT - 1)) && (y_pixel == 10'(V_ACT - 1));
    assign busy     = (state != ST_IDLE);

    pixel_tally #(.CNT_W(CNT_W)) u_tally (
        .clk        (clk),
        .reset      (reset),
        .clr        (tally_clr),
        .en         (tally_en),
        .in_polygon (in_polygon),
        .bg_pixel   (bg_pixel),
        .poly_cnt   (poly_t),
        .fill_cnt   (fill_t),
        .spill_cnt  (spill_t)
    );

    always_comb begin
        state_nxt = state;
        tally_clr = 1'b0;
        tally_en  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (judge_en && first_px) begin
                    state_nxt = ST_COLLECT;
                    tally_clr = 1'b1;
                    tally_en  = 1'b1;
                end
            end
            ST_COLLECT: begin
                if (!judge_en) begin
                    state_nxt = ST_IDLE;
                end else begin
                    tally_en = DE;
                    if (last_px)
                        state_nxt = ST_LATCH;
                end
            end
            ST_LATCH: state_nxt = ST_EVAL;
            ST_EVAL:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Stage p1: ratio tests become integer compares of scaled products.
    always_ff @(posedge clk) begin
        if (state == ST_LATCH) begin
            a_p1 <= PROD_W'(fill_t) * PROD_W'(100);
            p_p1 <= PROD_W'(poly_t) * PROD_W'(PERFECT_PCT);
            g_p1 <= PROD_W'(poly_t) * PROD_W'(GOOD_PCT);
            s_p1 <= PROD_W'(spill_t) * PROD_W'(100);
            t_p1 <= (PROD_W'(fill_t) + PROD_W'(spill_t)) * PROD_W'(SPILL_PCT);
        end
    end

    // Stage p2: compare and grade, registered into the outputs on the EVAL edge.
    assign spill_ok_p2 = (s_p1 <= t_p1);
    assign grade_p2    = grade_of(poly_t != '0, spill_ok_p2, a_p1, p_p1, g_p1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            score_valid <= 1'b0;
            grade       <= MISS;
            fill_cnt    <= '0;
            spill_cnt   <= '0;
            poly_cnt    <= '0;
            combo       <= 8'd0;
        end else begin
            state       <= state_nxt;
            score_valid <= (state == ST_EVAL);
            if (state == ST_EVAL) begin
                grade     <= grade_p2;
                fill_cnt  <= fill_t;
                spill_cnt <= spill_t;
                poly_cnt  <= poly_t;
                combo     <= (grade_p2 == MISS) ? 8'd0 : sat_inc8(combo);
            end else if (state == ST_IDLE && !judge_en) begin
                combo <= 8'd0;
            end
        end
    end

endmodule

// File: tb/tb_pose_match_scorer.sv
// Directed bench for pose_match_scorer on an 8x4 raster with default percentages.
module tb_pose_match_scorer;

    localparam int H  = 8;
    localparam int V  = 4;
    localparam int CW = 19;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          DE = 1'b0;
    logic [9:0]    x_pixel = '0;
    logic [9:0]    y_pixel = '0;
    logic          in_polygon = 1'b0;
    logic          bg_pixel = 1'b1;
    logic          judge_en = 1'b0;
    logic          score_valid;
    logic [1:0]    grade;
    logic [CW-1:0] fill_cnt;
    logic [CW-1:0] spill_cnt;
    logic [CW-1:0] poly_cnt;
    logic [7:0]    combo;
    logic          busy;

    int total = 0;
    int bad   = 0;

    pose_match_scorer #(
        .H_ACT(H), .V_ACT(V), .CNT_W(CW),
        .PERFECT_PCT(90), .GOOD_PCT(70), .SPILL_PCT(20)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .DE          (DE),
        .x_pixel     (x_pixel),
        .y_pixel     (y_pixel),
        .in_polygon  (in_polygon),
        .bg_pixel    (bg_pixel),
        .judge_en    (judge_en),
        .score_valid (score_valid),
        .grade       (grade),
        .fill_cnt    (fill_cnt),
        .spill_cnt   (spill_cnt),
        .poly_cnt    (poly_cnt),
        .combo       (combo),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input int g, input int p, input int f,
                             input int s, input int c);
        chk({tag, ".grade"}, 32'(grade), 32'(g));
        chk({tag, ".poly"},  32'(poly_cnt), 32'(p));
        chk({tag, ".fill"},  32'(fill_cnt), 32'(f));
        chk({tag, ".spill"}, 32'(spill_cnt), 32'(s));
        chk({tag, ".combo"}, 32'(combo), 32'(c));
    endtask

    // Pixel i is inside the polygon when i<np; foreground for i<nf and for np<=i<np+ns.
    task automatic run_frame(input int np, input int nf, input int ns,
                             input int drop_idx, input int rise_idx, input int rst_idx);
        for (int i = 0; i < H * V; i++) begin
            @(negedge clk);
            if (i == drop_idx) judge_en = 1'b0;
            if (i == rise_idx) judge_en = 1'b1;
            if (i == rst_idx) begin
                reset = 1'b0;
                #1;
                chk("rst_mid.sv",    32'(score_valid), 32'd0);
                chk("rst_mid.busy",  32'(busy), 32'd0);
                check_out("rst_mid", 0, 0, 0, 0, 0);
            end
            if (rst_idx >= 0 && i == rst_idx + 1) reset = 1'b1;
            DE         = 1'b1;
            x_pixel    = 10'(i % H);
            y_pixel    = 10'(i / H);
            in_polygon = (i < np);
            bg_pixel   = !((i < nf) || (i >= np && i < np + ns));
        end
    endtask

    task automatic wait_result(input string tag, input bit exp_res);
        int   first_k = 0;
        int   pulses  = 0;
        logic busy_t1 = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) begin
                DE         = 1'b0;
                in_polygon = 1'b0;
                bg_pixel   = 1'b1;
                busy_t1    = busy;
            end
            if (score_valid === 1'b1) begin
                pulses++;
                if (first_k == 0) first_k = k;
            end
        end
        if (exp_res) begin
            chk({tag, ".latency"}, 32'(first_k), 32'd3);
            chk({tag, ".pulses"},  32'(pulses), 32'd1);
            chk({tag, ".busy"},    32'(busy_t1), 32'd1);
        end else begin
            chk({tag, ".noresult"}, 32'(pulses), 32'd0);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset.sv",   32'(score_valid), 32'd0);
        chk("reset.busy", 32'(busy), 32'd0);
        check_out("reset", 0, 0, 0, 0, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        judge_en = 1'b1;

        // A=3000>=P=2880, S=0<=T=600
        run_frame(32, 30, 0, -1, -1, -1);
        wait_result("perfect", 1'b1);
        check_out("perfect", 2, 32, 30, 0, 1);

        // A=1500: P=1800 fails, G=1400 passes; S=200<=T=340
        run_frame(20, 15, 2, -1, -1, -1);
        wait_result("good", 1'b1);
        check_out("good", 1, 20, 15, 2, 2);

        // A=1000<G=1400
        run_frame(20, 10, 2, -1, -1, -1);
        wait_result("miss", 1'b1);
        check_out("miss", 0, 20, 10, 2, 0);

        run_frame(32, 30, 0, -1, -1, -1);
        wait_result("perfect2", 1'b1);
        check_out("perfect2", 2, 32, 30, 0, 1);

        // Full fill but S=500>T=300
        run_frame(10, 10, 5, -1, -1, -1);
        wait_result("spill", 1'b1);
        check_out("spill", 0, 10, 10, 5, 0);

        run_frame(20, 15, 2, -1, -1, -1);
        wait_result("good2", 1'b1);
        check_out("good2", 1, 20, 15, 2, 1);

        // judge_en drops at (0,2): no result, outputs hold, combo clears in IDLE
        run_frame(32, 30, 0, 16, -1, -1);
        wait_result("abort", 1'b0);
        check_out("abort", 1, 20, 15, 2, 0);

        // judge_en rises at (3,1): partial frame must not be graded
        run_frame(32, 30, 0, -1, 11, -1);
        wait_result("midentry", 1'b0);
        check_out("midentry", 1, 20, 15, 2, 0);

        // Empty polygon and no foreground: every ratio passes but poly==0 forces MISS
        run_frame(0, 0, 0, -1, -1, -1);
        wait_result("poly0", 1'b1);
        check_out("poly0", 0, 0, 0, 0, 0);

        run_frame(32, 30, 0, -1, -1, -1);
        wait_result("perfect3", 1'b1);
        check_out("perfect3", 2, 32, 30, 0, 1);

        // Reset during COLLECT, then the next full frame grades normally
        run_frame(32, 30, 0, -1, -1, 16);
        wait_result("rst_partial", 1'b0);
        run_frame(20, 15, 2, -1, -1, -1);
        wait_result("after_rst", 1'b1);
        check_out("after_rst", 1, 20, 15, 2, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
